// File: rtl/rr_replay_pkg.sv
// Shared definitions for the record/replay decoder tree: channel width field
// size, width/group arithmetic used to derive static slice offsets, and
// elaboration-time parameter sanity checks.
package rr_replay_pkg;

  localparam int unsigned RR_CHANNEL_WIDTH_BITS = 8;
  localparam int unsigned RR_MAX_CHANNELS       = 32;
  localparam int unsigned RR_CH_IDX_W           = $clog2(RR_MAX_CHANNELS);
  localparam int unsigned RR_MAX_GROUPS         = 32;
  localparam int unsigned RR_GRP_IDX_W          = $clog2(RR_MAX_GROUPS);
  localparam int unsigned RR_GRP_CNT_BITS       = 8;

  // Fixed-size carriers so helper functions can take any channel/group count.
  typedef logic [RR_MAX_CHANNELS-1:0][RR_CHANNEL_WIDTH_BITS-1:0] rr_width_vec_t;
  typedef logic [RR_MAX_GROUPS-1:0][RR_GRP_CNT_BITS-1:0]         rr_grp_cnt_vec_t;

  // Sum of widths of channels [first, first+cnt).
  function automatic int unsigned rr_width_sum(rr_width_vec_t widths, int unsigned first,
                                               int unsigned cnt);
    int unsigned sum;
    sum = 0;
    for (int unsigned i = 0; i < cnt; i++) begin
      sum = sum + 32'(widths[RR_CH_IDX_W'(first + i)]);
    end
    return sum;
  endfunction

  // Index of the first channel belonging to group grp.
  function automatic int unsigned rr_group_start(rr_grp_cnt_vec_t cnt, int unsigned grp);
    int unsigned sum;
    sum = 0;
    for (int unsigned i = 0; i < grp; i++) begin
      sum = sum + 32'(cnt[RR_GRP_IDX_W'(i)]);
    end
    return sum;
  endfunction

  // Groups must tile the channel list exactly.
  function automatic bit rr_group_cnt_ok(rr_grp_cnt_vec_t cnt, int unsigned num_groups,
                                         int unsigned total);
    return rr_group_start(cnt, num_groups) == total;
  endfunction

  // FIFO depth must be a power of two so the pointers wrap naturally.
  function automatic bit rr_depth_ok(int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/rr_demarshal_fifo.sv
// Per-group beat FIFO for the demarshaller.
// Ports: clk, rstn (sync, active-low), push/din write side, full/empty status
// from registered occupancy, pop/dout read side. dout reads 0 while empty.
module rr_demarshal_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  empty,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         occ;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (occ == CW'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; push+pop together leaves occupancy as is.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rr_trace_demarshaller_n.sv
// N-way replay-trace demarshaller: unpacks one compacted logb beat into
// NUM_OUT contiguous channel groups, each buffered by its own FIFO so a slow
// group only stalls the input once its FIFO is full.
// Ports: clk, rstn (sync, active-low); in_valid/in_ready with in_logb_valid,
// in_logb_data (compacted), in_loge_valid; per-group out_valid/out_ready with
// out_logb_valid/out_logb_data at static group positions and out_loge_valid
// slice per group; perf_clear and perf_stall_cnt (32 bits per group).
// Optional: RR_DEMARSHAL_PERF_EN enables saturating per-group stall counters;
// when undefined perf_stall_cnt is tied to 0.
module rr_trace_demarshaller_n
  import rr_replay_pkg::*;
#(
  parameter int unsigned LOGB_CHANNEL_CNT = 3,
  parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
    {8'd4, 8'd16, 8'd8},
  parameter int unsigned LOGE_CHANNEL_CNT = 3,
  parameter int unsigned NUM_OUT          = 3,
  parameter int          GROUP_CNT [NUM_OUT] = '{1, 1, 1},
  parameter int unsigned DEPTH            = 2,
  localparam int unsigned FULL_WIDTH =
    rr_width_sum(rr_width_vec_t'(CHANNEL_WIDTHS), 0, LOGB_CHANNEL_CNT)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LOGB_CHANNEL_CNT-1:0]          in_logb_valid,
  input  logic [FULL_WIDTH-1:0]                in_logb_data,
  input  logic [LOGE_CHANNEL_CNT-1:0]          in_loge_valid,
  output logic [NUM_OUT-1:0]                   out_valid,
  input  logic [NUM_OUT-1:0]                   out_ready,
  output logic [LOGB_CHANNEL_CNT-1:0]          out_logb_valid,
  output logic [FULL_WIDTH-1:0]                out_logb_data,
  output logic [NUM_OUT*LOGE_CHANNEL_CNT-1:0]  out_loge_valid,
  input  logic                                 perf_clear,
  output logic [NUM_OUT*32-1:0]                perf_stall_cnt
);

  localparam rr_width_vec_t CW_VEC  = rr_width_vec_t'(CHANNEL_WIDTHS);
  localparam int unsigned   SRC_W   = $clog2(FULL_WIDTH + 1);
  localparam int unsigned   LV_IDX_W = (LOGB_CHANNEL_CNT > 1) ? $clog2(LOGB_CHANNEL_CNT) : 1;
  localparam int unsigned   GI_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  // Repack the unpacked GROUP_CNT array into the package carrier type.
  function automatic rr_grp_cnt_vec_t pack_group_cnt();
    rr_grp_cnt_vec_t v;
    v = '0;
    for (int i = 0; i < int'(NUM_OUT); i++) begin
      v[RR_GRP_IDX_W'(i)] = RR_GRP_CNT_BITS'(GROUP_CNT[GI_W'(i)]);
    end
    return v;
  endfunction

  localparam rr_grp_cnt_vec_t GCNT_VEC = pack_group_cnt();

  if (!rr_group_cnt_ok(GCNT_VEC, NUM_OUT, LOGB_CHANNEL_CNT)) begin : g_bad_group_cnt
    $error("GROUP_CNT does not sum to LOGB_CHANNEL_CNT");
  end
  if (!rr_depth_ok(DEPTH)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (NUM_OUT < 2) begin : g_bad_num_out
    $error("NUM_OUT must be at least 2");
  end

  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] empty;
  logic               push;

  // Ready depends only on registered occupancy (and reset), never on out_ready.
  assign in_ready = rstn && !(|full);
  assign push     = in_valid && in_ready;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_grp
    localparam int unsigned CS   = rr_group_start(GCNT_VEC, k);
    localparam int unsigned CN   = GROUP_CNT[k];
    localparam int unsigned GW   = rr_width_sum(CW_VEC, CS, CN);
    localparam int unsigned GOFF = rr_width_sum(CW_VEC, 0, CS);
    localparam int unsigned PW   = CN + GW + LOGE_CHANNEL_CNT;

    logic [SRC_W-1:0] src;
    logic [PW-1:0]    din;
    logic [PW-1:0]    dout;
    logic             pop;

    // Compacted source offset: widths of valid channels in earlier groups.
    always_comb begin
      src = '0;
      for (int c = 0; c < int'(CS); c++) begin
        if (in_logb_valid[LV_IDX_W'(c)]) src = src + SRC_W'(CW_VEC[RR_CH_IDX_W'(c)]);
      end
    end

    // Logical shift zero-fills anything read past FULL_WIDTH.
    assign din = {in_logb_valid[CS +: CN], GW'(in_logb_data >> src), in_loge_valid};

    assign out_valid[k] = !empty[k];
    assign pop          = out_valid[k] && out_ready[k];

    rr_demarshal_fifo #(
      .DATA_WIDTH (PW),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .din   (din),
      .full  (full[k]),
      .empty (empty[k]),
      .pop   (pop),
      .dout  (dout)
    );

    assign out_logb_valid[CS +: CN]                              = dout[PW-1 -: CN];
    assign out_logb_data[GOFF +: GW]                             = dout[LOGE_CHANNEL_CNT +: GW];
    assign out_loge_valid[k*LOGE_CHANNEL_CNT +: LOGE_CHANNEL_CNT] = dout[LOGE_CHANNEL_CNT-1:0];

`ifdef RR_DEMARSHAL_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of cycles the group holds data its consumer refuses.
    always_ff @(posedge clk) begin
      if (!rstn || perf_clear) begin
        stall_q <= '0;
      end else if (out_valid[k] && !out_ready[k] && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end

    assign perf_stall_cnt[k*32 +: 32] = stall_q;
`else
    assign perf_stall_cnt[k*32 +: 32] = '0;
`endif
  end

`ifndef RR_DEMARSHAL_PERF_EN
  logic unused_perf_clear;
  assign unused_perf_clear = perf_clear;
`endif

endmodule

// File: tb/tb_rr_trace_demarshaller_n.sv
// Scoreboard bench for rr_trace_demarshaller_n in its default configuration
// (channel widths 8/16/4 from channel 0, one channel per group, DEPTH 2).
module tb_rr_trace_demarshaller_n;

  localparam int CH_W [3] = '{8, 16, 4};

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_logb_valid;
  logic [27:0] in_logb_data;
  logic [2:0]  in_loge_valid;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [2:0]  out_logb_valid;
  logic [27:0] out_logb_data;
  logic [8:0]  out_loge_valid;
  logic        perf_clear;
  logic [95:0] perf_stall_cnt;

  always #5 clk = ~clk;

  rr_trace_demarshaller_n dut (
    .clk            (clk),
    .rstn           (rstn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_logb_valid  (in_logb_valid),
    .in_logb_data   (in_logb_data),
    .in_loge_valid  (in_loge_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_logb_valid (out_logb_valid),
    .out_logb_data  (out_logb_data),
    .out_loge_valid (out_loge_valid),
    .perf_clear     (perf_clear),
    .perf_stall_cnt (perf_stall_cnt)
  );

  typedef struct packed {
    logic [2:0]  lv;
    logic [27:0] d;
    logic [2:0]  le;
  } beat_t;

  typedef struct packed {
    logic        lv;
    logic [15:0] d;
    logic [2:0]  le;
  } exp_t;

  int    checks = 0;
  int    errors = 0;
  exp_t  sb [3][$];
  beat_t pend [$];
  int    popped [3];
  int    n_acc;
  bit    acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Expected group-k view of a packed beat: walk channels with a data cursor.
  function automatic exp_t model(input int k, input beat_t b);
    exp_t        e;
    int          cur;
    logic [27:0] sh;
    logic [15:0] mask;
    cur = 0;
    e   = '0;
    for (int c = 0; c < 3; c++) begin
      if (c == k) begin
        sh   = b.d >> cur;
        mask = 16'((32'd1 << CH_W[c]) - 32'd1);
        e.d  = 16'(sh) & mask;
      end
      if (b.lv[c]) cur += CH_W[c];
    end
    e.lv = b.lv[k];
    e.le = b.le;
    return e;
  endfunction

  function automatic exp_t observe(input int k);
    case (k)
      0:       observe = {out_logb_valid[0], 16'(out_logb_data[7:0]),   out_loge_valid[2:0]};
      1:       observe = {out_logb_valid[1], out_logb_data[23:8],        out_loge_valid[5:3]};
      default: observe = {out_logb_valid[2], 16'(out_logb_data[27:24]), out_loge_valid[8:6]};
    endcase
  endfunction

  function automatic bit sb_busy();
    return (sb[0].size() != 0) || (sb[1].size() != 0) || (sb[2].size() != 0);
  endfunction

  // One clock: resolve handshakes at the negedge, then advance past posedge.
  task automatic tick();
    exp_t  e;
    exp_t  o;
    beat_t b;
    @(negedge clk);
    acc = 1'b0;
    if (!rstn) begin
      for (int k = 0; k < 3; k++) sb[k].delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          check($sformatf("g%0d_sb_nonempty", k), 32'(sb[k].size() != 0), 32'd1);
          if (sb[k].size() != 0) begin
            e = sb[k].pop_front();
            o = observe(k);
            check($sformatf("g%0d_logb_valid", k), 32'(o.lv), 32'(e.lv));
            check($sformatf("g%0d_loge_valid", k), 32'(o.le), 32'(e.le));
            if (e.lv) check($sformatf("g%0d_data", k), 32'(o.d), 32'(e.d));
            popped[k]++;
          end
        end
      end
      if (in_valid && in_ready) begin
        b = {in_logb_valid, in_logb_data, in_loge_valid};
        for (int k = 0; k < 3; k++) sb[k].push_back(model(k, b));
        acc = 1'b1;
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_front();
    if (pend.size() != 0) begin
      in_valid      = 1'b1;
      in_logb_valid = pend[0].lv;
      in_logb_data  = pend[0].d;
      in_loge_valid = pend[0].le;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_front();
      tick();
      if (acc) void'(pend.pop_front());
    end
    drive_front();
  endtask

  task automatic add_random(input int n);
    beat_t b;
    repeat (n) begin
      b.lv = 3'($urandom);
      b.d  = 28'($urandom);
      b.le = 3'($urandom);
      pend.push_back(b);
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((pend.size() != 0 || sb_busy()) && n < max_cycles) begin
      run(1);
      n++;
    end
    check("drain_left", 32'(pend.size() + sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
  endtask

  task automatic clear_counts();
    n_acc = 0;
    for (int k = 0; k < 3; k++) popped[k] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_stall;
    rstn          = 1'b0;
    in_valid      = 1'b0;
    in_logb_valid = '0;
    in_logb_data  = '0;
    in_loge_valid = '0;
    out_ready     = '0;
    perf_clear    = 1'b0;
    clear_counts();

    // Reset state and release
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_perf", perf_stall_cnt[31:0], 32'd0);
    rstn = 1'b1;
    tick();
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);

    // Single beat unpacking
    pend.push_back('{lv: 3'b101, d: 28'h00005AA, le: 3'b010});
    run(1);
    check("unpack_acc", 32'(acc), 32'd1);
    check("unpack_out_valid", 32'(out_valid), 32'h7);
    check("unpack_g0_data", 32'(out_logb_data[7:0]), 32'hAA);
    check("unpack_g1_lv", 32'(out_logb_valid[1]), 32'd0);
    check("unpack_g2_data", 32'(out_logb_data[27:24]), 32'h5);
    check("unpack_loge", 32'(out_loge_valid), 32'h092);
    out_ready = 3'b111;
    drain(10);
    check("unpack_empty", 32'(out_valid), 32'd0);

    // Independent drain with group 1 stalled, then full-plus-pop
    clear_counts();
    out_ready = 3'b101;
    add_random(4);
    run(6);
    check("drain_acc2", 32'(n_acc), 32'd2);
    check("drain_in_ready", 32'(in_ready), 32'd0);
    check("drain_g0_pops", 32'(popped[0]), 32'd2);
    check("drain_g1_pops", 32'(popped[1]), 32'd0);
    check("drain_g2_pops", 32'(popped[2]), 32'd2);
    out_ready = 3'b111;
    check("fp_in_ready", 32'(in_ready), 32'd0);
    run(1);
    check("fp_no_acc", 32'(acc), 32'd0);
    run(1);
    check("fp_acc_next", 32'(acc), 32'd1);
    drain(20);
    check("drain_g0_total", 32'(popped[0]), 32'd4);
    check("drain_g1_total", 32'(popped[1]), 32'd4);
    check("drain_g2_total", 32'(popped[2]), 32'd4);

    // Full throughput with every consumer ready
    clear_counts();
    add_random(8);
    run(8);
    check("tput_acc", 32'(n_acc), 32'd8);
    drain(10);

    // Reset with beats buffered
    clear_counts();
    out_ready = 3'b000;
    add_random(2);
    run(2);
    check("mr_acc", 32'(n_acc), 32'd2);
    check("mr_buffered", 32'(out_valid), 32'h7);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    clear_counts();
    add_random(1);
    out_ready = 3'b111;
    drain(10);
    check("mr_g0_pops", 32'(popped[0]), 32'd1);
    check("mr_g1_pops", 32'(popped[1]), 32'd1);
    check("mr_g2_pops", 32'(popped[2]), 32'd1);

    // Stall counters
`ifdef RR_DEMARSHAL_PERF_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif
    out_ready  = 3'b000;
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
    add_random(1);
    run(1);
    repeat (10) tick();
    check("perf_g0", perf_stall_cnt[31:0], exp_stall);
    check("perf_g2", perf_stall_cnt[95:64], exp_stall);
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
    check("perf_clear_g0", perf_stall_cnt[31:0], 32'd0);
    check("perf_clear_g1", perf_stall_cnt[63:32], 32'd0);
    out_ready = 3'b111;
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
